// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction ROM
// and registers the fetched word into the IF/ID pipeline register.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal fetch; flush > stall > advance each cycle
// HALTED | PC frozen, IF/ID drains to bubbles; only reset leaves it
module fetch_stage #(
    parameter int          DATA_W    = 32,
    parameter int          ROM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    localparam int         ROM_AW    = $clog2(ROM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] target_i,
    input  logic              halt_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_id_o,
    output logic [DATA_W-1:0] pc_id_o,
    output logic              valid_id_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_id_q, instr_id_d;
    logic [DATA_W-1:0] pc_id_q, pc_id_d;
    logic              valid_id_q, valid_id_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC[DATA_W-1:0];
            instr_id_q  <= NOP_INSTR[DATA_W-1:0];
            pc_id_q     <= '0;
            valid_id_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            valid_id_q  <= valid_id_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_id_d  = instr_id_q;
        pc_id_d     = pc_id_q;
        valid_id_d  = valid_id_q;
        fetch_cnt_d = fetch_cnt_q;

        unique case (state_q)
            RUN: begin
                if (flush_i) begin
                    // Redirect overrides both stall and halt; halt is dropped.
                    pc_d       = {target_i[DATA_W-1:2], 2'b00};
                    instr_id_d = NOP_INSTR[DATA_W-1:0];
                    valid_id_d = 1'b0;
                end else begin
                    if (!stall_i) begin
                        instr_id_d  = rom_data_i;
                        pc_id_d     = pc_q;
                        valid_id_d  = 1'b1;
                        pc_d        = pc_q + DATA_W'(4);
                        fetch_cnt_d = fetch_cnt_q + 32'd1;
                    end
                    if (halt_i) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!stall_i) begin
                    instr_id_d = NOP_INSTR[DATA_W-1:0];
                    valid_id_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign rom_addr_o  = pc_q[ROM_AW+1:2];
    assign pc_o        = pc_q;
    assign instr_id_o  = instr_id_q;
    assign pc_id_o     = pc_id_q;
    assign valid_id_o  = valid_id_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed scenarios followed by random
// stall/flush/halt/reset traffic checked against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall_i, flush_i, halt_i;
    logic [31:0] target_i;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] pc_o, instr_id_o, pc_id_o, fetch_cnt_o;
    logic        valid_id_o;

    logic [31:0] rom [1024];
    assign rom_data_i = rom[rom_addr_o];

    fetch_stage dut (
        .CLK(CLK), .RESET(RESET), .stall_i(stall_i), .flush_i(flush_i),
        .target_i(target_i), .halt_i(halt_i), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .pc_o(pc_o), .instr_id_o(instr_id_o),
        .pc_id_o(pc_id_o), .valid_id_o(valid_id_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_id;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pc_id, m_cnt;
    logic        m_valid, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pc_id = 32'h0; m_valid = 1'b0;
        m_cnt = 32'h0; m_halted = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_instr"}, instr_id_o, NOP);
        chk({tag, "_pc_id"}, pc_id_o, 32'h0);
        chk({tag, "_valid"}, {31'b0, valid_id_o}, 32'h0);
        chk({tag, "_cnt"}, fetch_cnt_o, 32'h0);
        chk({tag, "_rom_addr"}, {22'b0, rom_addr_o}, 32'h0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] tg, input logic hl);
        exp_t e;
        logic [31:0] word;
        stall_i = st; flush_i = fl; target_i = tg; halt_i = hl;
        #1;
        chk("rom_addr", {22'b0, rom_addr_o}, (m_pc / 4) % 1024);
        chk("pc_now", pc_o, m_pc);
        word = rom[(m_pc / 4) % 1024];
        if (!m_halted) begin
            if (fl) begin
                m_pc = tg - (tg % 4);
                m_instr = NOP;
                m_valid = 1'b0;
            end else begin
                if (!st) begin
                    m_instr = word;
                    m_pc_id = m_pc;
                    m_valid = 1'b1;
                    m_pc = m_pc + 4;
                    m_cnt = m_cnt + 1;
                end
                if (hl) m_halted = 1'b1;
            end
        end else if (!st) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc_id = m_pc_id; e.valid = m_valid; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    // Called at a falling edge; pulses reset between clock edges.
    task automatic do_reset(input string tag);
        stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; target_i = 32'h0;
        #2 RESET = 1'b1;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc_o, e.pc);
                chk("instr_id", instr_id_o, e.instr);
                chk("pc_id", pc_id_o, e.pc_id);
                chk("valid_id", {31'b0, valid_id_o}, {31'b0, e.valid});
                chk("fetch_cnt", fetch_cnt_o, e.cnt);
            end
        end
    end

    initial begin : stim
        int halted_for;
        for (int k = 0; k < 1024; k++) rom[k] = k + 1;
        RESET = 1'b1; stall_i = 0; flush_i = 0; halt_i = 0; target_i = 0;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        check_reset_vals("reset0");

        // run, stall at pc=8, release
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        // flush to misaligned 0x41 at pc=0x10
        cycle(0, 1, 32'h41, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        // flush beats stall; ROM wrap at 0xFFC
        cycle(1, 1, 32'hFFE, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        // flush beats halt; PC wrap at 2^32
        cycle(0, 1, 32'hFFFF_FFFC, 1); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        // halt at pc=0x20 then drain, including a stalled cycle while halted
        cycle(0, 1, 32'h20, 0);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 32'h100, 0);
        cycle(0, 1, 32'h100, 0);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        do_reset("reset_mid");
        cycle(0, 0, 0, 0);

        for (int k = 0; k < 1024; k++) rom[k] = $urandom;
        halted_for = 0;
        for (int i = 0; i < 3000; i++) begin
            logic st, fl, hl;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            hl = ($urandom_range(0, 63) == 0);
            tg = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            if (m_halted) halted_for++;
            if (halted_for > 6 || (i % 400) == 399) begin
                do_reset("reset_rand");
                halted_for = 0;
            end else begin
                cycle(st, fl, tg, hl);
            end
        end

        stall_i = 0; flush_i = 0; halt_i = 0;
        repeat (2) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
